mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of stream bytes and of the memory data word.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the width of the memory address (256 locations).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a load session; sampled only in IDLE or DONE.
REQ-006 SHALL have port in_data, input, DATA_W bits: incoming stream byte.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the loader accepts in_data this cycle.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: write address to the downstream 256x8 memory.
REQ-010 SHALL have port mem_data, output, DATA_W bits: write data to the memory.
REQ-011 SHALL have port mem_we, output, 1 bit: memory write enable; the memory commits on the negedge inside the asserted cycle.
REQ-012 SHALL have port busy, output, 1 bit: session in progress; used as CPU hold.
REQ-013 SHALL have port done, output, 1 bit: session finished; level signal.
REQ-014 SHALL have port error, output, 1 bit: checksum mismatch; meaningful only when done=1.

Function
REQ-015 SHALL implement states IDLE, GET_ADDR, GET_LEN, LOAD, CHECK, DONE.
REQ-016 SHALL transfer a byte only on a posedge where in_valid=1 and in_ready=1, with in_ready=1 exactly in GET_ADDR, GET_LEN, LOAD and CHECK.
REQ-017 SHALL go from IDLE or DONE to GET_ADDR on start=1, clearing done, error and the checksum accumulator.
REQ-018 SHALL, in GET_ADDR, load the accepted byte into the address pointer and go to GET_LEN.
REQ-019 SHALL, in GET_LEN, load the accepted byte into the remaining count (0 means 256) and go to LOAD.
REQ-020 SHALL, for each byte accepted in LOAD, drive mem_we=1, mem_addr=pointer and mem_data=byte in the following cycle only; then increment the pointer modulo 256 (255 wraps to 0) and decrement the count.
REQ-021 SHALL leave LOAD after the last counted byte: to CHECK if LOADER_CHECKSUM_EN is defined, otherwise to DONE.
REQ-022 SHALL, in CHECK, compare the accepted byte with the 8-bit modulo-256 sum of all LOAD bytes, set error=1 on mismatch, and go to DONE.
REQ-023 SHALL hold busy=1 in every state except IDLE and DONE, and hold done=1 only in DONE.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL tolerate arbitrary in_valid gaps: no timeout, and state and counters are held while in_valid=0.
REQ-026 SHALL keep mem_we=0 outside the one-cycle write pulses, including during GET_ADDR, GET_LEN and CHECK.

Reset
REQ-027 SHALL on reset go to IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, error=0, and the count and checksum cleared.
REQ-028 SHALL, when reset is asserted mid-session, abort in the same cycle and suppress any pending mem_we pulse.

Configuration
REQ-029 SHALL, with LOADER_CHECKSUM_EN defined, include the accumulator and CHECK state as specified.
REQ-030 SHALL, with LOADER_CHECKSUM_EN undefined, omit the accumulator and CHECK state, tie error to 0, and go directly from LOAD to DONE.

Structure
REQ-031 SHALL take the state enum encoding and the LEN_ZERO_IS_256 constant from the shared package cpu_pkg.
REQ-032 SHALL be a single module with no sub-modules; the checksum accumulator SHALL be inline.

Verification
REQ-033 SHALL verify: start, then bytes 0x10, 0x03, 0xAA, 0xBB, 0xCC, 0x31 -> writes at 0x10/0x11/0x12 with AA/BB/CC, done=1, error=0.
REQ-034 SHALL verify: the same stream with final byte 0x30 -> done=1, error=1, and memory still written.
REQ-035 SHALL verify: address 0xFE, length 0x03 -> writes at 0xFE, 0xFF, 0x00 (wrap).
REQ-036 SHALL verify: length 0x00 -> exactly 256 writes before CHECK.
REQ-037 SHALL verify: reset asserted on the cycle after the second LOAD byte is accepted -> no write for that byte, IDLE, and all outputs 0.
REQ-038 SHALL verify: in_valid toggled 1,0,0,1 and start pulsed mid-session -> no lost or duplicate writes, and start is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory loader: FSM state encoding and length convention.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_LEN  = 3'd2,
    ST_LOAD     = 3'd3,
    ST_CHECK    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // A length byte of zero requests a full 256-byte page.
  localparam bit LEN_ZERO_IS_256 = 1'b1;

endpackage

// File: rtl/mem_loader.sv
// Stream-to-memory loader: start, address byte, length byte, payload, optional checksum byte.
// Define LOADER_CHECKSUM_EN to include the checksum accumulator and CHECK state.
module mem_loader
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output state_e            dbg_state
);

  // Stream handshake: a byte moves on a posedge where in_valid and in_ready are both 1;
  // in_ready depends only on state, never on in_valid, and the source may idle arbitrarily.
  localparam int CNT_W = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e AFTER_LOAD = ST_CHECK;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
`else
  localparam state_e AFTER_LOAD = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_int;
  logic              accept;
  logic [CNT_W-1:0]  len_cnt;

  assign ready_int = (state_q == ST_GET_ADDR) || (state_q == ST_GET_LEN) ||
                     (state_q == ST_LOAD)     || (state_q == ST_CHECK);
  assign accept    = in_valid && ready_int;
  assign len_cnt   = (in_data == '0 && LEN_ZERO_IS_256) ? (CNT_W'(1) << ADDR_W)
                                                        : CNT_W'(in_data);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_GET_ADDR;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_GET_ADDR: begin
        if (accept) begin
          ptr_d   = ADDR_W'(in_data);
          state_d = ST_GET_LEN;
        end
      end
      ST_GET_LEN: begin
        if (accept) begin
          cnt_d   = len_cnt;
          state_d = (len_cnt == '0) ? AFTER_LOAD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = in_data;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (cnt_q == CNT_W'(1)) state_d = AFTER_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          err_d   = (in_data != sum_q);
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Reset masks the control outputs immediately so a pending write pulse never reaches memory.
  assign in_ready  = ready_int && !reset;
  assign mem_we    = we_q && !reset;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE) && !reset;
  assign done      = (state_q == ST_DONE) && !reset;
`ifdef LOADER_CHECKSUM_EN
  assign error     = err_q && !reset;
`else
  assign error     = 1'b0;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: the driver pushes expected memory writes, a negedge monitor pops them.
module tb_mem_loader;
  import cpu_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, mem_we, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  state_e            dbg_state;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_writes = 0;

  mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the memory commits on the negedge of a write cycle, so sample there.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("write_addr_data", {mem_addr, mem_data}, exp_q.pop_front());
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic idle_gap(input int max_gap);
    int k;
    k = $urandom_range(0, max_gap);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Present one byte and hold it until the loader takes it (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic run_session(input logic [7:0] addr, input logic [7:0] len, input bit fixed,
                             input bit bad_chk, input bit start_mid, input int max_gap);
    int n;
    logic [7:0] sum, b;
    bit exp_err;
    n = (len == 8'd0) ? 256 : int'(len);
    sum = 8'd0;
    n_writes = 0;
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    chk("done_cleared", 32'(done), 0);
    send_byte(addr);
    idle_gap(max_gap);
    send_byte(len);
    for (int i = 0; i < n; i++) begin
      b = fixed ? 8'(8'hAA + 8'h11 * i) : 8'($urandom);
      exp_q.push_back({8'(addr + 8'(i)), b});
      sum = sum + b;
      if (start_mid && i == 1) begin
        // two idle cycles with start held high inside the session
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_ignored_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("start_ignored_busy", 32'(busy), 1);
      end else begin
        idle_gap(max_gap);
      end
      send_byte(b);
    end
`ifdef LOADER_CHECKSUM_EN
    chk("state_after_load", 32'(dbg_state), 32'(ST_CHECK));
    chk("no_done_before_check", 32'(done), 0);
    idle_gap(max_gap);
    send_byte(bad_chk ? (sum ^ 8'h01) : sum);
    exp_err = bad_chk;
`else
    chk("state_after_load", 32'(dbg_state), 32'(ST_DONE));
    exp_err = 1'b0;
`endif
    wait_done();
    chk("busy_in_done", 32'(busy), 0);
    chk("error_flag", 32'(error), 32'(exp_err));
    chk("ready_in_done", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("write_count", 32'(n_writes), 32'(n));
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_data"}, 32'(mem_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    logic [7:0] b0, b1;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    run_session(8'h10, 8'h03, 1'b1, 1'b0, 1'b0, 0);
    run_session(8'h10, 8'h03, 1'b1, 1'b1, 1'b0, 2);
    run_session(8'hFE, 8'h03, 1'b0, 1'b0, 1'b0, 1);
    run_session(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    run_session(8'h40, 8'h04, 1'b0, 1'b0, 1'b1, 0);

    // Abort in the cycle after the second payload byte is accepted.
    pulse_start();
    send_byte(8'h20);
    send_byte(8'h05);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    exp_q.push_back({8'h20, b0});
    send_byte(b0);
    send_byte(b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_we", 32'(mem_we), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    chk("abort_queue", 32'(exp_q.size()), 0);
    exp_q.delete();

    for (int s = 0; s < 6; s++) begin
      run_session(8'($urandom), 8'($urandom_range(1, 24)), 1'b0, 1'($urandom_range(0, 1)),
                  1'b0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
